// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// sequencer states and the default operand width.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 div_mode,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic                 q_bit
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      diff     = rem_sh - {1'b0, operand};
      q_bit    = 1'b0;
      acc_next = acc;
      if (div_mode) begin
         // Remainder stays below 2*divisor, so bit WIDTH of diff is a clean sign.
         q_bit    = ~diff[WIDTH];
         acc_next = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                     acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers,
// MTHI/MTLO write port and pipeline stall request.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic [WIDTH-1:0]   rt_val,
   input  logic               abort,
   input  logic               mf_read,
   input  logic               mt_hi,
   input  logic               mt_lo,
   input  logic [WIDTH-1:0]   mt_data,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic               stall_req
);

   localparam int CW = $clog2(WIDTH);

   state_e               state;
   logic [1:0]           op_q;
   logic [WIDTH-1:0]     opnd;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic                 neg_lo;
   logic                 neg_hi;

   logic [2*WIDTH-1:0]   acc_step;
   logic                 q_bit;

   logic                 is_div;
   logic                 sign_a;
   logic                 sign_b;
   logic [WIDTH-1:0]     a_abs;
   logic [WIDTH-1:0]     b_abs;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (is_div),
      .acc      (acc),
      .operand  (opnd),
      .acc_next (acc_step),
      .q_bit    (q_bit)
   );

   // While latched, acc[WIDTH-1:0] holds rs and opnd holds rt until PREP.
   always_comb begin
      is_div   = op_is_div(op_q);
      sign_a   = op_is_signed(op_q) & acc[WIDTH-1];
      sign_b   = op_is_signed(op_q) & opnd[WIDTH-1];
      a_abs    = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      b_abs    = sign_b ? -opnd : opnd;
      prod_fix = neg_lo ? -acc : acc;
      if (is_div) begin
         fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end else begin
         fix_lo = prod_fix[WIDTH-1:0];
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_q        <= 2'b00;
         opnd        <= '0;
         acc         <= '0;
         cnt         <= '0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  op_q  <= op;
                  acc   <= {{WIDTH{1'b0}}, rs_val};
                  opnd  <= rt_val;
                  state <= ST_PREP;
               end
            end
            ST_PREP: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (is_div && opnd == '0) begin
                  state       <= ST_DONE;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
               end else begin
                  // Multiply keeps the multiplier in acc; divide keeps the dividend.
                  opnd   <= is_div ? b_abs : a_abs;
                  acc    <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                  neg_lo <= sign_a ^ sign_b;
                  neg_hi <= is_div ? sign_a : (sign_a ^ sign_b);
                  cnt    <= CW'(WIDTH-1);
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  acc <= acc_step | {{(2*WIDTH-1){1'b0}}, q_bit};
                  if (cnt == '0) state <= ST_FIX;
                  else           cnt   <= cnt - 1'b1;
               end
            end
            ST_FIX: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  hi    <= fix_hi;
                  lo    <= fix_lo;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         // HI/LO are free in IDLE/DONE; the case above never writes them there.
         if ((state == ST_IDLE || state == ST_DONE) && mt_hi) hi <= mt_data;
         if ((state == ST_IDLE || state == ST_DONE) && mt_lo) lo <= mt_data;
      end
   end

   assign busy = (state != ST_IDLE);

   // DONE already holds valid HI/LO and accepts MT writes, but cannot take a new op.
   assign stall_req = (busy && state != ST_DONE && (start || mf_read || mt_hi || mt_lo)) ||
                      (state == ST_DONE && start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table + scoreboard queue,
// followed by hand sequences for divide-by-zero, stalls, abort and reset.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic           clk, reset, start, abort, mf_read, mt_hi, mt_lo;
   logic [1:0]     op;
   logic [W-1:0]   rs_val, rt_val, mt_data, hi, lo;
   logic           busy, done, div_by_zero, stall_req;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi, lo;
      logic         dbz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .abort(abort), .mf_read(mf_read),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
      .hi(hi), .lo(lo), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .stall_req(stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cyc_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Independent reference using the simulator's own 64-bit arithmetic.
   task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l);
      longint          sa, sbv, p, q, r;
      longint unsigned pu;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (o)
         OP_MULT:  begin p = sa * sbv; h = p[63:32]; l = p[31:0]; end
         OP_MULTU: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
         OP_DIV:   begin q = sa / sbv; r = sa % sbv; h = r[31:0]; l = q[31:0]; end
         default:  begin h = a % b; l = a / b; end
      endcase
   endtask

   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input int lat);
      exp_t e;
      e.hi = eh; e.lo = el; e.dbz = ed; e.lat = lat;
      sb.push_back(e);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      cyc = 0;
      cyc_step();
      start = 1'b0;
   endtask

   task automatic run_to_done(input int max);
      exp_t e;
      bit   got;
      got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("hi", 64'(hi), 64'(e.hi));
               chk("lo", 64'(lo), 64'(e.lo));
               chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
               chk("done_latency", 64'(cyc), 64'(e.lat));
            end
         end else begin
            cyc_step();
         end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL done_timeout actual=no_done required=done (cycle %0d)", cyc);
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   task automatic finish_op();
      cyc_step();
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
   endtask

   initial begin
      vec_t       v;
      logic [W-1:0] h, l;
      logic [W-1:0] prev_hi, prev_lo;

      reset = 1'b1; start = 1'b0; abort = 1'b0; mf_read = 1'b0;
      mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; op = 2'b00; rs_val = '0; rt_val = '0;

      vecs.push_back('{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB});
      vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
      vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
      vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
      vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
      vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
      vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF});
      vecs.push_back('{OP_DIVU,  32'd3,        32'd5,        32'd3,        32'd0});
      vecs.push_back('{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0});
      for (int i = 0; i < 6; i++) begin
         v.op = 2'($urandom_range(0, 3));
         v.a  = $urandom;
         v.b  = $urandom;
         if (v.op[1] && v.b == '0) v.b = 32'd1;
         model(v.op, v.a, v.b, h, l);
         v.hi = h; v.lo = l;
         vecs.push_back(v);
      end

      cyc_step();
      cyc_step();
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dbz", 64'(div_by_zero), 64'd0);
      reset = 1'b0;
      cyc_step();

      foreach (vecs[i]) begin
         launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, W + 3);
         chk("busy_cycle1", 64'(busy), 64'd1);
         run_to_done(60);
         finish_op();
      end

      // Divide by zero leaves preloaded HI/LO untouched.
      mt_hi = 1'b1; mt_data = 32'h11;
      cyc_step();
      mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 32'h22;
      cyc_step();
      mt_lo = 1'b0;
      chk("mthi_write", 64'(hi), 64'h11);
      chk("mtlo_write", 64'(lo), 64'h22);
      launch(OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 2);
      run_to_done(10);
      finish_op();

      // MULTU with MFHI/MFLO probes mid-run and in DONE.
      launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W + 3);
      while (cyc < 10) cyc_step();
      mf_read = 1'b1;
      #1;
      chk("stall_mf_busy", 64'(stall_req), 64'd1);
      mf_read = 1'b0;
      run_to_done(60);
      mf_read = 1'b1;
      #1;
      chk("stall_mf_done", 64'(stall_req), 64'd0);
      mf_read = 1'b0;
      finish_op();
      prev_hi = 32'hFFFFFFFE;
      prev_lo = 32'h00000001;

      // Abort at cycle 10; start/MTHI while busy stall and are ignored.
      op = OP_MULT; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
      cyc = 0;
      cyc_step();
      start = 1'b0;
      while (cyc < 5) cyc_step();
      start = 1'b1; op = OP_DIVU;
      #1;
      chk("stall_start_busy", 64'(stall_req), 64'd1);
      start = 1'b0;
      cyc_step();
      mt_hi = 1'b1; mt_data = 32'hDEAD;
      #1;
      chk("stall_mt_busy", 64'(stall_req), 64'd1);
      mt_hi = 1'b0;
      while (cyc < 10) cyc_step();
      abort = 1'b1;
      cyc_step();
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_hi_kept", 64'(hi), 64'(prev_hi));
      chk("abort_lo_kept", 64'(lo), 64'(prev_lo));
      cyc_step();
      chk("abort_no_done_late", 64'(done), 64'd0);
      launch(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, W + 3);
      run_to_done(60);
      finish_op();

      // Synchronous reset in the middle of a divide.
      op = OP_DIV; rs_val = 32'd1000; rt_val = 32'd9; start = 1'b1;
      cyc = 0;
      cyc_step();
      start = 1'b0;
      while (cyc < 20) cyc_step();
      reset = 1'b1;
      cyc_step();
      reset = 1'b0;
      chk("midreset_busy", 64'(busy), 64'd0);
      chk("midreset_hi", 64'(hi), 64'd0);
      chk("midreset_lo", 64'(lo), 64'd0);
      chk("midreset_done", 64'(done), 64'd0);
      start = 1'b1; abort = 1'b1; op = OP_MULT;
      cyc_step();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 64'(busy), 64'd0);
      for (int i = 0; i < 40; i++) begin
         cyc_step();
         if (done !== 1'b0) chk("no_done_after_reset", 64'(done), 64'd0);
      end
      chk("idle_after_reset", 64'(busy), 64'd0);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
